// File: rtl/matrix_comm_pkg.sv
// Shared types and helpers for the matrix-converter commutation controller.
package matrix_comm_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_STEADY,
      ST_STEP1,
      ST_STEP2,
      ST_STEP3,
      ST_STEP4,
      ST_FAULT
   } leg_state_e;

   localparam int unsigned SEL_NUL = 0;

   // Gate bit of (leg, input): forward device sits one above reverse.
   function automatic int unsigned sout_idx(input int unsigned leg, input int unsigned inp,
                                            input logic fwd, input int unsigned n_in);
      return (leg * n_in + inp) * 2 + (fwd ? 32'd1 : 32'd0);
   endfunction

endpackage

// File: rtl/matrix_comm_leg.sv
// One output leg: current-sign-based four-step commutation FSM with step dwell counter.
module matrix_comm_leg
   import matrix_comm_pkg::*;
#(
   parameter int unsigned N_IN        = 3,
   parameter int unsigned SEL_W       = $clog2(N_IN + 1),
   parameter int unsigned STEP_CYCLES = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                fault,
   input  logic                sign,
   input  logic [SEL_W-1:0]    sel,
   output logic [2*N_IN-1:0]   gates,
   output logic                busy
);

   localparam int unsigned      CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [SEL_W-1:0] NUL   = SEL_W'(SEL_NUL);

   leg_state_e          state_q, state_n;
   logic [SEL_W-1:0]    cur_q, cur_n, tgt_q, tgt_n, req;
   logic                sgn_q, sgn_n;
   logic [CNT_W-1:0]    cnt_q, cnt_n;
   logic [2*N_IN-1:0]   gates_n;
   logic                busy_n, step_done, sample, sel_ok;

   // Device mask for input s (1-based select); s = NUL or out of range gives zero.
   function automatic logic [2*N_IN-1:0] dev_mask(input logic [SEL_W-1:0] s,
                                                  input logic f, input logic r);
      logic [2*N_IN-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < N_IN; i++) begin
         if (s == SEL_W'(i + 1)) begin
            m[sout_idx(0, i, 1'b1, N_IN)] = f;
            m[sout_idx(0, i, 1'b0, N_IN)] = r;
         end
      end
      return m;
   endfunction

   // Selections above N_IN are treated as NUL.
   always_comb begin
      sel_ok = 1'b0;
      for (int unsigned i = 0; i < N_IN; i++) begin
         if (sel == SEL_W'(i + 1)) sel_ok = 1'b1;
      end
      req = sel_ok ? sel : NUL;
   end

   // Next state; sgn picks the conducting device (p) kept on through the overlap.
   always_comb begin
      state_n   = state_q;
      cur_n     = cur_q;
      tgt_n     = tgt_q;
      sgn_n     = sgn_q;
      cnt_n     = cnt_q;
      gates_n   = gates;
      sample    = 1'b0;
      step_done = (cnt_q == CNT_W'(STEP_CYCLES - 1));

      if (fault || state_q == ST_FAULT) begin
         state_n = ST_FAULT;
         gates_n = '0;
         cnt_n   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               gates_n = '0;
               if (start) begin
                  state_n = ST_STEADY;
                  cur_n   = NUL;
               end
            end
            ST_STEADY: sample = 1'b1;
            ST_STEP1: begin
               if (step_done) begin
                  state_n = ST_STEP2;
                  cnt_n   = '0;
                  gates_n = gates | dev_mask(tgt_q, sgn_q, ~sgn_q);
               end else begin
                  cnt_n = cnt_q + CNT_W'(1);
               end
            end
            ST_STEP2: begin
               if (step_done) begin
                  state_n = ST_STEP3;
                  cnt_n   = '0;
                  gates_n = gates & ~dev_mask(cur_q, sgn_q, ~sgn_q);
               end else begin
                  cnt_n = cnt_q + CNT_W'(1);
               end
            end
            ST_STEP3: begin
               if (step_done) begin
                  state_n = ST_STEP4;
                  cnt_n   = '0;
                  gates_n = gates | dev_mask(tgt_q, ~sgn_q, sgn_q);
                  cur_n   = tgt_q;
               end else begin
                  cnt_n = cnt_q + CNT_W'(1);
               end
            end
            ST_STEP4: begin
               if (step_done) sample = 1'b1;
               else           cnt_n = cnt_q + CNT_W'(1);
            end
            default: begin
               state_n = ST_IDLE;
               gates_n = '0;
               cnt_n   = '0;
            end
         endcase

         // STEP4 doubles as the single-step dwell for NUL transitions.
         if (sample) begin
            state_n = ST_STEADY;
            cnt_n   = '0;
            if (req == cur_q) begin
               state_n = ST_STEADY;
            end else if (cur_q == NUL) begin
               gates_n = gates | dev_mask(req, 1'b1, 1'b1);
               cur_n   = req;
               state_n = ST_STEP4;
            end else if (req == NUL) begin
               gates_n = gates & ~dev_mask(cur_q, 1'b1, 1'b1);
               cur_n   = NUL;
               state_n = ST_STEP4;
            end else begin
               tgt_n   = req;
               sgn_n   = sign;
               gates_n = gates & ~dev_mask(cur_q, ~sign, sign);
               state_n = ST_STEP1;
            end
         end

         if (!start) begin
            state_n = ST_IDLE;
            gates_n = '0;
            cnt_n   = '0;
            cur_n   = NUL;
         end
      end

      busy_n = (state_n inside {ST_STEP1, ST_STEP2, ST_STEP3, ST_STEP4});
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cur_q   <= NUL;
         tgt_q   <= NUL;
         sgn_q   <= 1'b0;
         cnt_q   <= '0;
         gates   <= '0;
         busy    <= 1'b0;
      end else begin
         state_q <= state_n;
         cur_q   <= cur_n;
         tgt_q   <= tgt_n;
         sgn_q   <= sgn_n;
         cnt_q   <= cnt_n;
         gates   <= gates_n;
         busy    <= busy_n;
      end
   end

endmodule

// File: rtl/matrix_commutator.sv
// N_IN x N_OUT matrix-converter switch controller: per-leg commutation FSMs plus latched short fault.
module matrix_commutator
   import matrix_comm_pkg::*;
#(
   parameter int unsigned N_IN        = 3,
   parameter int unsigned N_OUT       = 3,
   parameter int unsigned SEL_W       = $clog2(N_IN + 1),
   parameter int unsigned STEP_CYCLES = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [N_IN-1:0]           shorts,
   input  logic [N_OUT-1:0]          CurrentSign,
   input  logic [N_OUT*SEL_W-1:0]    DesiredLoad,
   output logic [2*N_IN*N_OUT-1:0]   Sout,
   output logic [N_OUT-1:0]          busy,
   output logic                      short
);

   logic fault_c;

   // Fault reaches every leg on the same edge it is first seen, then stays latched.
   assign fault_c = (|shorts) | short;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          short <= 1'b0;
      else if (|shorts) short <= 1'b1;
   end

   for (genvar o = 0; o < N_OUT; o++) begin : g_leg
      localparam int unsigned BASE = sout_idx(o, 0, 1'b0, N_IN);
      localparam int unsigned FLD  = (N_OUT - 1 - o) * SEL_W;

      matrix_comm_leg #(
         .N_IN        (N_IN),
         .SEL_W       (SEL_W),
         .STEP_CYCLES (STEP_CYCLES)
      ) u_leg (
         .clk   (clk),
         .rst   (rst),
         .start (start),
         .fault (fault_c),
         .sign  (CurrentSign[o]),
         .sel   (DesiredLoad[FLD +: SEL_W]),
         .gates (Sout[BASE +: 2*N_IN]),
         .busy  (busy[o])
      );
   end

endmodule
